// File: rtl/pipe_control_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_control_unit_pkg
// Description : Opcode constants, ALU-op codes and pipeline control bundles
//               shared by the main pipeline control unit and its decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_control_unit_pkg;

  localparam logic [5:0] OPCODE_RTYPE = 6'h00;
  localparam logic [5:0] OPCODE_J     = 6'h02;
  localparam logic [5:0] OPCODE_BEQ   = 6'h04;
  localparam logic [5:0] OPCODE_ADDI  = 6'h08;
  localparam logic [5:0] OPCODE_ANDI  = 6'h0C;
  localparam logic [5:0] OPCODE_ORI   = 6'h0D;
  localparam logic [5:0] OPCODE_LW    = 6'h23;
  localparam logic [5:0] OPCODE_SW    = 6'h2B;

  localparam logic [2:0] ALU_OP_NOP    = 3'd0;
  localparam logic [2:0] ALU_OP_ADD    = 3'd1;
  localparam logic [2:0] ALU_OP_SUB    = 3'd2;
  localparam logic [2:0] ALU_OP_AND    = 3'd3;
  localparam logic [2:0] ALU_OP_OR     = 3'd4;
  localparam logic [2:0] ALU_OP_R_TYPE = 3'd7;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       branch;
    logic [2:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{
    reg_dst: 1'b0, alu_src: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
    mem_to_reg: 1'b0, reg_write: 1'b0, branch: 1'b0, alu_op: ALU_OP_NOP
  };

  typedef struct packed {
    ctrl_t      ctrl;
    logic [5:0] funct;
    logic [4:0] rt;
    logic       illegal;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '{
    ctrl: CTRL_BUBBLE, funct: 6'd0, rt: 5'd0, illegal: 1'b0
  };

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic branch;
    logic mem_to_reg;
    logic reg_write;
  } ex_mem_t;

  localparam ex_mem_t EX_MEM_BUBBLE = '{
    mem_read: 1'b0, mem_write: 1'b0, branch: 1'b0,
    mem_to_reg: 1'b0, reg_write: 1'b0
  };

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } mem_wb_t;

  localparam mem_wb_t MEM_WB_BUBBLE = '{mem_to_reg: 1'b0, reg_write: 1'b0};

  function automatic ctrl_t rtype_ctrl();
    ctrl_t c;
    c           = CTRL_BUBBLE;
    c.reg_dst   = 1'b1;
    c.reg_write = 1'b1;
    c.alu_op    = ALU_OP_R_TYPE;
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_control_unit_if
// Description : ID-stage inputs and per-stage control outputs of the pipeline
//               control unit; master is the control unit, slave the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_control_unit_if;

  logic [31:0] instr_id;
  logic        id_valid;
  logic        flush;
  logic        stall;
  logic        id_jump;
  logic [2:0]  ex_alu_op;
  logic [5:0]  ex_funct;
  logic        ex_reg_dst;
  logic        ex_alu_src;
  logic [4:0]  ex_rt;
  logic        mem_read;
  logic        mem_write;
  logic        mem_branch;
  logic        wb_reg_write;
  logic        wb_mem_to_reg;
  logic        illegal_op;

  modport master (
    input  instr_id, id_valid, flush,
    output stall, id_jump, ex_alu_op, ex_funct, ex_reg_dst, ex_alu_src, ex_rt,
           mem_read, mem_write, mem_branch, wb_reg_write, wb_mem_to_reg,
           illegal_op
  );

  modport slave (
    output instr_id, id_valid, flush,
    input  stall, id_jump, ex_alu_op, ex_funct, ex_reg_dst, ex_alu_src, ex_rt,
           mem_read, mem_write, mem_branch, wb_reg_write, wb_mem_to_reg,
           illegal_op
  );

endinterface
`default_nettype wire

// File: rtl/pipe_control_unit_main_decoder.sv
`default_nettype none
// ============================================================================
// Module      : pipe_control_unit_main_decoder
// Description : Combinational opcode -> ID/EX control bundle decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_control_unit_main_decoder
  import pipe_control_unit_pkg::*;
#(
  parameter bit ILLEGAL_AS_NOP = 1'b1
) (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  input  logic       valid,
  output id_ex_t     bundle
);

  ctrl_t ctrl;
  logic  known;

  always_comb begin
    ctrl  = CTRL_BUBBLE;
    known = 1'b1;
    case (opcode)
      OPCODE_RTYPE: ctrl = rtype_ctrl();
      OPCODE_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.alu_op     = ALU_OP_ADD;
      end
      OPCODE_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      OPCODE_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_OP_SUB;
      end
      OPCODE_ADDI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      OPCODE_ANDI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_OP_AND;
      end
      OPCODE_ORI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_OP_OR;
      end
      OPCODE_J: ctrl = CTRL_BUBBLE;
      default: begin
        known = 1'b0;
        if (!ILLEGAL_AS_NOP) ctrl = rtype_ctrl();
      end
    endcase
  end

  // Jumps resolve in ID, so only the illegal tag ever rides along with a bubble.
  always_comb begin
    bundle = ID_EX_BUBBLE;
    if (valid && opcode != OPCODE_J) begin
      if (!known && ILLEGAL_AS_NOP) begin
        bundle.illegal = 1'b1;
      end else begin
        bundle.ctrl  = ctrl;
        bundle.funct = funct;
        bundle.rt    = rt;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipe_control_unit
// Description : MIPS 5-stage main control: ID decode, ID/EX, EX/MEM, MEM/WB
//               control registers, load-use stall, bubble and flush handling.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_control_unit
  import pipe_control_unit_pkg::*;
#(
  parameter bit ILLEGAL_AS_NOP = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  pipe_control_unit_if.master bus
);

  logic [5:0] id_opcode;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic [5:0] id_funct;
  logic       id_live;
  logic       load_use;
  logic       stall_int;

  id_ex_t  id_decoded;
  id_ex_t  id_ex_d,  id_ex_q;
  ex_mem_t ex_mem_d, ex_mem_q;
  mem_wb_t mem_wb_d, mem_wb_q;

  assign id_opcode = bus.instr_id[31:26];
  assign id_rs     = bus.instr_id[25:21];
  assign id_rt     = bus.instr_id[20:16];
  assign id_funct  = bus.instr_id[5:0];

  // The all-zero word is the canonical nop and must not decode as an R-type write.
  assign id_live = bus.id_valid && (bus.instr_id != 32'h0);

  pipe_control_unit_main_decoder #(
    .ILLEGAL_AS_NOP (ILLEGAL_AS_NOP)
  ) u_main_decoder (
    .opcode (id_opcode),
    .funct  (id_funct),
    .rt     (id_rt),
    .valid  (id_live),
    .bundle (id_decoded)
  );

  assign load_use = id_ex_q.ctrl.mem_read && (id_ex_q.rt != 5'd0) &&
                    ((id_ex_q.rt == id_rs) || (id_ex_q.rt == id_rt)) &&
                    bus.id_valid;
  assign stall_int = load_use && !bus.flush;

  always_comb begin
    id_ex_d = id_decoded;
    if (bus.flush || stall_int) id_ex_d = ID_EX_BUBBLE;

    ex_mem_d = '{
      mem_read:   id_ex_q.ctrl.mem_read,
      mem_write:  id_ex_q.ctrl.mem_write,
      branch:     id_ex_q.ctrl.branch,
      mem_to_reg: id_ex_q.ctrl.mem_to_reg,
      reg_write:  id_ex_q.ctrl.reg_write
    };
    if (bus.flush) ex_mem_d = EX_MEM_BUBBLE;

    // The taken branch sitting in EX/MEM still retires through MEM/WB on a flush.
    mem_wb_d = '{mem_to_reg: ex_mem_q.mem_to_reg, reg_write: ex_mem_q.reg_write};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_ex_q  <= ID_EX_BUBBLE;
      ex_mem_q <= EX_MEM_BUBBLE;
      mem_wb_q <= MEM_WB_BUBBLE;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  assign bus.stall         = stall_int;
  assign bus.id_jump       = (id_opcode == OPCODE_J) && bus.id_valid && !bus.flush;
  assign bus.ex_alu_op     = id_ex_q.ctrl.alu_op;
  assign bus.ex_funct      = id_ex_q.funct;
  assign bus.ex_reg_dst    = id_ex_q.ctrl.reg_dst;
  assign bus.ex_alu_src    = id_ex_q.ctrl.alu_src;
  assign bus.ex_rt         = id_ex_q.rt;
  assign bus.illegal_op    = id_ex_q.illegal;
  assign bus.mem_read      = ex_mem_q.mem_read;
  assign bus.mem_write     = ex_mem_q.mem_write;
  assign bus.mem_branch    = ex_mem_q.branch;
  assign bus.wb_reg_write  = mem_wb_q.reg_write;
  assign bus.wb_mem_to_reg = mem_wb_q.mem_to_reg;

endmodule
`default_nettype wire

// File: tb/tb_pipe_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_control_unit
// Description : Self-checking bench: instruction-level pipeline model plus
//               directed scenarios and randomized streams.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_control_unit;
  import pipe_control_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  pipe_control_unit_if bus();

  pipe_control_unit #(.ILLEGAL_AS_NOP(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef enum int {K_BUB, K_LIVE, K_ILL} kind_e;
  typedef struct {
    kind_e       k;
    logic [31:0] ins;
  } slot_t;

  slot_t m_ex, m_mem, m_wb;
  bit    known = 1'b0;
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic slot_t bub();
    slot_t s;
    s.k = K_BUB; s.ins = 32'h0;
    return s;
  endfunction

  function automatic slot_t enter(logic [31:0] ins, logic v);
    slot_t s;
    s = bub();
    if (v && ins != 32'h0 && ins[31:26] != 6'h02) begin
      s.ins = ins;
      case (ins[31:26])
        6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0C, 6'h0D: s.k = K_LIVE;
        default: s.k = K_ILL;
      endcase
    end
    return s;
  endfunction

  function automatic bit is_op(slot_t s, logic [5:0] op);
    return s.k == K_LIVE && s.ins[31:26] == op;
  endfunction

  function automatic logic [2:0] exp_alu(slot_t s);
    if (s.k != K_LIVE) return ALU_OP_NOP;
    case (s.ins[31:26])
      6'h00:               return ALU_OP_R_TYPE;
      6'h04:               return ALU_OP_SUB;
      6'h0C:               return ALU_OP_AND;
      6'h0D:               return ALU_OP_OR;
      default:             return ALU_OP_ADD;
    endcase
  endfunction

  function automatic bit writes_reg(slot_t s);
    return is_op(s, 6'h00) || is_op(s, 6'h23) || is_op(s, 6'h08) ||
           is_op(s, 6'h0C) || is_op(s, 6'h0D);
  endfunction

  function automatic bit uses_imm(slot_t s);
    return is_op(s, 6'h23) || is_op(s, 6'h2B) || is_op(s, 6'h08) ||
           is_op(s, 6'h0C) || is_op(s, 6'h0D);
  endfunction

  function automatic bit exp_stall();
    logic [4:0] r;
    r = m_ex.ins[20:16];
    return is_op(m_ex, 6'h23) && r != 5'd0 &&
           (r == bus.instr_id[25:21] || r == bus.instr_id[20:16]) &&
           bus.id_valid && !bus.flush;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    if (!known) return;
    check("stall",         32'(bus.stall),         32'(exp_stall()));
    check("id_jump",       32'(bus.id_jump),
          32'(bus.instr_id[31:26] == 6'h02 && bus.id_valid && !bus.flush));
    check("ex_alu_op",     32'(bus.ex_alu_op),     32'(exp_alu(m_ex)));
    check("ex_funct",      32'(bus.ex_funct),      m_ex.k == K_LIVE ? 32'(m_ex.ins[5:0]) : 32'h0);
    check("ex_rt",         32'(bus.ex_rt),         m_ex.k == K_LIVE ? 32'(m_ex.ins[20:16]) : 32'h0);
    check("ex_reg_dst",    32'(bus.ex_reg_dst),    32'(is_op(m_ex, 6'h00)));
    check("ex_alu_src",    32'(bus.ex_alu_src),    32'(uses_imm(m_ex)));
    check("illegal_op",    32'(bus.illegal_op),    32'(m_ex.k == K_ILL));
    check("mem_read",      32'(bus.mem_read),      32'(is_op(m_mem, 6'h23)));
    check("mem_write",     32'(bus.mem_write),     32'(is_op(m_mem, 6'h2B)));
    check("mem_branch",    32'(bus.mem_branch),    32'(is_op(m_mem, 6'h04)));
    check("wb_reg_write",  32'(bus.wb_reg_write),  32'(writes_reg(m_wb)));
    check("wb_mem_to_reg", 32'(bus.wb_mem_to_reg), 32'(is_op(m_wb, 6'h23)));
  endtask

  task automatic model_step();
    bit s;
    s = exp_stall();
    if (reset) begin
      m_ex = bub(); m_mem = bub(); m_wb = bub();
      known = 1'b1;
    end else begin
      m_wb  = m_mem;
      m_mem = bus.flush ? bub() : m_ex;
      m_ex  = (bus.flush || s) ? bub() : enter(bus.instr_id, bus.id_valid);
    end
  endtask

  task automatic apply(logic [31:0] ins, logic v, logic f, logic r);
    bus.instr_id = ins;
    bus.id_valid = v;
    bus.flush    = f;
    reset        = r;
    @(negedge clk);
    cmp_all();
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [31:0] mk(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                     logic [4:0] rd, logic [5:0] fn);
    return {op, rs, rt, rd, 5'd0, fn};
  endfunction

  logic [31:0] i_add, i_lw, i_sw, i_beq, i_use, i_lw0, i_use0, i_ill, i_j;
  logic [5:0]  ops [10];

  initial begin
    i_add  = mk(6'h00, 5'd1, 5'd2, 5'd3, 6'h20);
    i_lw   = mk(6'h23, 5'd1, 5'd5, 5'd0, 6'h04);
    i_sw   = mk(6'h2B, 5'd1, 5'd2, 5'd0, 6'h08);
    i_beq  = mk(6'h04, 5'd3, 5'd4, 5'd0, 6'h02);
    i_use  = mk(6'h00, 5'd5, 5'd6, 5'd7, 6'h20);
    i_lw0  = mk(6'h23, 5'd1, 5'd0, 5'd0, 6'h00);
    i_use0 = mk(6'h00, 5'd0, 5'd0, 5'd7, 6'h20);
    i_ill  = mk(6'h3F, 5'd1, 5'd2, 5'd3, 6'h11);
    i_j    = mk(6'h02, 5'd0, 5'd0, 5'd0, 6'h10);
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h02, 6'h3F, 6'h15};

    bus.instr_id = i_lw; bus.id_valid = 1'b1; bus.flush = 1'b0; reset = 1'b1;
    @(posedge clk); #1;

    // Reset held two cycles with a load in ID, then released.
    apply(i_lw, 1, 0, 1); advance();
    apply(i_lw, 1, 0, 1);
    check("rst_ex_alu_op", 32'(bus.ex_alu_op), 32'(ALU_OP_NOP));
    check("rst_stall", 32'(bus.stall), 32'h0);
    advance();
    apply(32'h0, 0, 0, 0);
    check("rst_after_mem_read", 32'(bus.mem_read), 32'h0);
    check("rst_after_wb_write", 32'(bus.wb_reg_write), 32'h0);
    check("rst_after_ex_funct", 32'(bus.ex_funct), 32'h0);
    advance();

    // add, lw, sw, beq stream.
    apply(i_add, 1, 0, 0); advance();
    apply(i_lw, 1, 0, 0);
    check("str_ex_rtype", 32'(bus.ex_alu_op), 32'(ALU_OP_R_TYPE));
    check("str_ex_funct", 32'(bus.ex_funct), 32'h20);
    advance();
    apply(i_sw, 1, 0, 0);
    check("str_ex_lw_add", 32'(bus.ex_alu_op), 32'(ALU_OP_ADD));
    advance();
    apply(i_beq, 1, 0, 0);
    check("str_mem_read_lw", 32'(bus.mem_read), 32'h1);
    advance();
    apply(32'h0, 1, 0, 0);
    check("str_ex_sub", 32'(bus.ex_alu_op), 32'(ALU_OP_SUB));
    check("str_mem_write_sw", 32'(bus.mem_write), 32'h1);
    check("str_wb_write_lw", 32'(bus.wb_reg_write), 32'h1);
    check("str_wb_m2r_lw", 32'(bus.wb_mem_to_reg), 32'h1);
    advance();

    // Load-use hazard, then the rt=0 variant.
    apply(i_lw, 1, 0, 0); advance();
    apply(i_use, 1, 0, 0);
    check("lu_stall", 32'(bus.stall), 32'h1);
    advance();
    apply(i_use, 1, 0, 0);
    check("lu_stall_once", 32'(bus.stall), 32'h0);
    check("lu_ex_bubble", 32'(bus.ex_alu_op), 32'(ALU_OP_NOP));
    check("lu_mem_read", 32'(bus.mem_read), 32'h1);
    advance();
    apply(32'h0, 1, 0, 0);
    check("lu_ex_use", 32'(bus.ex_alu_op), 32'(ALU_OP_R_TYPE));
    advance();
    apply(i_lw0, 1, 0, 0); advance();
    apply(i_use0, 1, 0, 0);
    check("lu_rt0_stall", 32'(bus.stall), 32'h0);
    advance();
    apply(32'h0, 1, 0, 0); advance();

    // Flush with beq in MEM, lw in EX, add in ID.
    apply(i_beq, 1, 0, 0); advance();
    apply(mk(6'h23, 5'd1, 5'd9, 5'd0, 6'h0), 1, 0, 0); advance();
    apply(i_add, 1, 1, 0);
    check("fl_mem_branch", 32'(bus.mem_branch), 32'h1);
    advance();
    apply(32'h0, 1, 0, 0);
    check("fl_mem_read", 32'(bus.mem_read), 32'h0);
    check("fl_ex_bubble", 32'(bus.ex_alu_op), 32'(ALU_OP_NOP));
    check("fl_wb_beq", 32'(bus.wb_reg_write), 32'h0);
    advance();
    apply(32'h0, 1, 0, 0);
    check("fl_wb_lw_killed", 32'(bus.wb_reg_write), 32'h0);
    advance();
    apply(32'h0, 1, 0, 0);
    check("fl_wb_add_killed", 32'(bus.wb_reg_write), 32'h0);
    advance();

    // Unknown opcode.
    apply(i_ill, 1, 0, 0); advance();
    apply(32'h0, 1, 0, 0);
    check("ill_pulse", 32'(bus.illegal_op), 32'h1);
    check("ill_ex_nop", 32'(bus.ex_alu_op), 32'(ALU_OP_NOP));
    advance();
    apply(32'h0, 1, 0, 0);
    check("ill_pulse_end", 32'(bus.illegal_op), 32'h0);
    check("ill_mem_read", 32'(bus.mem_read), 32'h0);
    advance();
    apply(32'h0, 1, 0, 0);
    check("ill_wb_write", 32'(bus.wb_reg_write), 32'h0);
    advance();

    // Flush and load-use hazard together.
    apply(i_lw, 1, 0, 0); advance();
    apply(i_use, 1, 1, 0);
    check("fs_stall_masked", 32'(bus.stall), 32'h0);
    advance();
    apply(32'h0, 1, 0, 0);
    check("fs_ex_bubble", 32'(bus.ex_alu_op), 32'(ALU_OP_NOP));
    check("fs_mem_killed", 32'(bus.mem_read), 32'h0);
    advance();

    // Jump detection.
    apply(i_j, 1, 0, 0);
    check("j_jump", 32'(bus.id_jump), 32'h1);
    advance();
    apply(i_j, 1, 1, 0);
    check("j_flushed", 32'(bus.id_jump), 32'h0);
    advance();
    apply(32'h0, 1, 0, 0); advance();

    // Randomized streams with small register numbers to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      logic [5:0] op;
      op = ops[$urandom_range(0, 9)];
      if (op == 6'h15) op = 6'($urandom);
      apply(mk(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 31)), 6'($urandom)),
            $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 49) == 0);
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
